// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction prefetch path: reset PC, NOP encoding,
// fetch FSM states and the buffer entry layout.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQ        = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of fetched {word address, instruction} pairs.
// Flush empties the buffer and takes priority over push/pop.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  fb_entry_t                push_entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: streams sequential words into a small buffer and
// restarts fetching whenever the core's PC departs from the expected stream.
module instr_prefetch
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        PCUpdate,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   next_addr_q, next_addr_d;
    logic [31:0]   req_addr_q, req_addr_d;

    fb_entry_t     head, push_entry;
    logic [CW-1:0] count;
    logic          empty, pop, push, flush, redirect, room;
    logic [29:0]   expected;
    logic [31:0]   pc_aligned;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^PC[1:0];
    assign pc_aligned    = {PC[31:2], 2'b00};

    assign InstrValid = !empty && (head.addr == PC[31:2]);
    assign Instr      = InstrValid ? head.data : NOP_INSTR;
    assign pop        = PCUpdate && InstrValid;
    assign expected   = empty ? next_addr_q[31:2] : head.addr;
    assign redirect   = (PC[31:2] != expected);
    assign room       = (count - CW'(pop)) < CW'(DEPTH);
    assign push_entry = '{addr: mem_addr[31:2], data: mem_rdata};

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk_i        (clk),
        .rst_ni       (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (flush),
        .head_o       (head),
        .count_o      (count),
        .empty_o      (empty)
    );

    // An IDLE request acked in the same cycle completes without visiting REQ,
    // which is what allows one instruction per cycle when memory acks at once.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        req_addr_d  = req_addr_q;
        mem_req     = 1'b0;
        mem_addr    = next_addr_q;
        push        = 1'b0;
        flush       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    flush       = 1'b1;
                    next_addr_d = pc_aligned;
                end else if (room && reset) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        push        = 1'b1;
                        next_addr_d = next_addr_q + 32'd4;
                    end else begin
                        state_d    = ST_REQ;
                        req_addr_d = next_addr_q;
                    end
                end
            end
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
                if (redirect) begin
                    flush       = 1'b1;
                    next_addr_d = pc_aligned;
                    state_d     = mem_ack ? ST_IDLE : ST_FLUSH_WAIT;
                end else if (mem_ack) begin
                    push        = 1'b1;
                    next_addr_d = req_addr_q + 32'd4;
                    state_d     = ST_IDLE;
                end
            end
            ST_FLUSH_WAIT: begin
                // Stale request must still complete; its data is dropped.
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
                if (redirect) next_addr_d = pc_aligned;
                if (mem_ack)  state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            next_addr_q <= RESET_PC;
            req_addr_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            req_addr_q  <= req_addr_d;
        end
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter: DEPTH, 2, number of instruction buffer entries (power of two, >=2).
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: PC  input  32  address of the instruction the core wants this cycle.
REQ-006 Port: PCUpdate  input  1  core consumes Instr this cycle; pops buffer head.
REQ-007 Port: Instr  output  32  instruction word for PC.
REQ-008 Port: InstrValid  output  1  Instr is the word at PC.
REQ-009 Port: mem_req  output  1  instruction-memory read request.
REQ-010 Port: mem_addr  output  32  word-aligned request address.
REQ-011 Port: mem_ack  input  1  request accepted; mem_rdata valid this cycle.
REQ-012 Port: mem_rdata  input  32  read data, sampled only when mem_req && mem_ack.

Function
REQ-013 Buffer entries SHALL hold {addr[31:2], data[31:0]}; FIFO order; count 0..DEPTH.
REQ-014 InstrValid SHALL be combinational: buffer non-empty && head.addr == PC[31:2]; PC[1:0] ignored.
REQ-015 Instr SHALL equal head.data when InstrValid = 1, else 32'h0000_0013 (NOP).
REQ-016 next_addr register SHALL hold the address of the next request; +4 per accepted request, wrapping 32'hFFFF_FFFC -> 0.
REQ-017 FSM states SHALL be IDLE, REQ, FLUSH_WAIT.
REQ-018 IDLE -> REQ when count (after this cycle's pop) < DEPTH and no redirect; mem_req = 1, mem_addr = next_addr.
REQ-019 In REQ/FLUSH_WAIT, mem_req SHALL remain 1 and mem_addr stable until mem_ack.
REQ-020 REQ with mem_ack: push {mem_addr, mem_rdata}, next_addr += 4, go IDLE; data visible on Instr the cycle after ack (latency 1, no bypass).
REQ-021 Redirect SHALL be detected when PC[31:2] != expected, where expected = head.addr if non-empty, else next_addr.
REQ-022 On redirect: clear buffer, next_addr <= {PC[31:2],2'b00}; from IDLE go IDLE; from REQ without ack go FLUSH_WAIT; from REQ with ack discard the data and go IDLE.
REQ-023 FLUSH_WAIT with mem_ack: discard mem_rdata, go IDLE; further redirects only update next_addr.
REQ-024 PCUpdate with InstrValid = 0 SHALL be ignored (no pop).
REQ-025 Simultaneous pop and push SHALL keep count unchanged; full buffer SHALL never receive a push.
REQ-026 Buffer full: no new request until a pop.

Reset
REQ-027 While reset = 0: state IDLE, count 0, next_addr = RESET_PC, mem_req 0, mem_addr RESET_PC, InstrValid 0, Instr NOP.
REQ-028 Reset asserted mid-request SHALL drop the request immediately; a late mem_ack after release SHALL be ignored unless mem_req = 1.
REQ-029 First request SHALL issue in the first cycle after reset release.

Structure
REQ-030 Shared package riscv_pkg SHALL hold RESET_PC default, NOP_INSTR (32'h0000_0013), and the FSM state encoding.
REQ-031 One sub-module fetch_buffer SHALL implement the DEPTH-entry FIFO (push, pop, flush, head, count).
REQ-032 Redirect logic, FSM and next_addr SHALL live in instr_prefetch.

Verification
REQ-033 Reset release, PC=0, mem_ack tied 1, rdata=addr+0x100 -> InstrValid cycle 2, Instr 0x100; streaming one instruction per cycle thereafter.
REQ-034 PCUpdate held 0, ack tied 1 -> exactly DEPTH requests (addr 0, 4), then mem_req 0 until a pop.
REQ-035 During REQ (ack held 0, addr 8), PC jumps to 0x40 -> FLUSH_WAIT; ack after 3 cycles discarded; next request addr 0x40; Instr from 0x40 valid one cycle after its ack.
REQ-036 PC=0xFFFF_FFFC, streaming -> next request addr 0x0000_0000.
REQ-037 reset pulsed low while mem_req = 1 -> mem_req 0 same cycle, count 0, InstrValid 0; restart at RESET_PC.
REQ-038 PC[1:0]=2'b10 with matching word in buffer -> InstrValid 1, same Instr as aligned PC.
